// File: rtl/light_sequencer.sv
// Traffic-light phase controller: sequences GREEN/YELLOW/RED through an external
// down-counter, with pedestrian early-yellow and a maintenance flashing-yellow mode.
module light_sequencer #(
  parameter int pCNT_WIDTH     = 5,
  parameter int pINIT_WIDTH    = 3,
  parameter int pTICK_DIV      = 50000000,
  parameter int pTICK_WIDTH    = 26,
  parameter int pPED_MIN_GREEN = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cnt_last,
  input  logic [pCNT_WIDTH-1:0]  cnt_val,
  input  logic                   ped_req,
  input  logic                   flash_req,
  output logic [pINIT_WIDTH-1:0] cnt_init,
  output logic                   cnt_en,
  output logic [pINIT_WIDTH-1:0] light,
  output logic                   ped_wait
);

  typedef enum logic [2:0] {
    ST_START,
    ST_GREEN,
    ST_YELLOW,
    ST_RED,
    ST_FLASH
  } state_t;

  localparam logic [pINIT_WIDTH-1:0] LP_GREEN  = pINIT_WIDTH'(1);
  localparam logic [pINIT_WIDTH-1:0] LP_YELLOW = pINIT_WIDTH'(2);
  localparam logic [pINIT_WIDTH-1:0] LP_RED    = pINIT_WIDTH'(4);

  state_t                  r_state;
  logic [pTICK_WIDTH-1:0]  r_presc;
  logic [pINIT_WIDTH-1:0]  r_cnt_init;
  logic [pINIT_WIDTH-1:0]  r_light;
  logic                    r_ped_wait;

  logic w_tick;
  logic w_in_phase;
  logic w_loaded;
  logic w_expire;
  logic w_shorten;
  logic w_enter_red;

  assign w_tick     = (r_presc == pTICK_WIDTH'(pTICK_DIV - 1));
  assign w_in_phase = (r_state == ST_GREEN) || (r_state == ST_YELLOW) || (r_state == ST_RED);
  // The counter reloads on the edge after cnt_init, so its outputs are stale until then.
  assign w_loaded   = (r_cnt_init == '0);
  assign w_expire   = w_in_phase && w_loaded && w_tick && cnt_last;
  assign w_shorten  = (r_state == ST_GREEN) && w_loaded && r_ped_wait &&
                      (cnt_val > pCNT_WIDTH'(pPED_MIN_GREEN));
  assign w_enter_red = !flash_req &&
                       (((r_state == ST_YELLOW) && w_expire) || (r_state == ST_FLASH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_START;
      r_presc    <= '0;
      r_cnt_init <= '0;
      r_light    <= '0;
      r_ped_wait <= 1'b0;
    end else begin
      // Realign the tick grid to each counter reload; free-run otherwise (incl. FLASH).
      if (!w_loaded || w_tick) r_presc <= '0;
      else                     r_presc <= r_presc + pTICK_WIDTH'(1);

      if (flash_req || w_enter_red) r_ped_wait <= 1'b0;
      else if (ped_req)             r_ped_wait <= 1'b1;

      r_cnt_init <= '0;
      if (flash_req) begin
        r_state <= ST_FLASH;
        if (r_state != ST_FLASH) r_light <= LP_YELLOW;
        else if (w_tick)         r_light <= r_light ^ LP_YELLOW;
      end else begin
        case (r_state)
          ST_START: begin
            r_state    <= ST_GREEN;
            r_light    <= LP_GREEN;
            r_cnt_init <= LP_GREEN;
          end
          ST_GREEN: begin
            if (w_expire || w_shorten) begin
              r_state    <= ST_YELLOW;
              r_light    <= LP_YELLOW;
              r_cnt_init <= LP_YELLOW;
            end
          end
          ST_YELLOW: begin
            if (w_expire) begin
              r_state    <= ST_RED;
              r_light    <= LP_RED;
              r_cnt_init <= LP_RED;
            end
          end
          ST_RED: begin
            if (w_expire) begin
              r_state    <= ST_GREEN;
              r_light    <= LP_GREEN;
              r_cnt_init <= LP_GREEN;
            end
          end
          ST_FLASH: begin
            r_state    <= ST_RED;
            r_light    <= LP_RED;
            r_cnt_init <= LP_RED;
          end
          default: begin
            r_state <= ST_START;
            r_light <= '0;
          end
        endcase
      end
    end
  end

  assign cnt_init = r_cnt_init;
  assign light    = r_light;
  assign ped_wait = r_ped_wait;
  assign cnt_en   = w_tick && w_in_phase && w_loaded;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with a small phase-counter model
// (green 14 / yellow 2 / red 17) and a 4-cycle tick.
module tb_light_sequencer;
  localparam int CW = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cnt_last;
  logic [CW-1:0] cnt_val;
  logic          ped_req = 1'b0;
  logic          flash_req = 1'b0;
  logic [IW-1:0] cnt_init;
  logic          cnt_en;
  logic [IW-1:0] light;
  logic          ped_wait;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  light_sequencer #(
    .pCNT_WIDTH(CW), .pINIT_WIDTH(IW), .pTICK_DIV(4), .pTICK_WIDTH(3), .pPED_MIN_GREEN(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cnt_last(cnt_last), .cnt_val(cnt_val),
    .ped_req(ped_req), .flash_req(flash_req), .cnt_init(cnt_init),
    .cnt_en(cnt_en), .light(light), .ped_wait(ped_wait)
  );

  // Phase counter model
  logic [CW-1:0] r_cval = '0;
  always @(posedge clk) begin
    if (cnt_init[0])                  r_cval <= 5'd14;
    else if (cnt_init[1])             r_cval <= 5'd2;
    else if (cnt_init[2])             r_cval <= 5'd17;
    else if (cnt_en && r_cval != 0)   r_cval <= r_cval - 5'd1;
  end
  assign cnt_val  = r_cval;
  assign cnt_last = (r_cval == 0);

  typedef struct {
    logic       ped;
    logic       flash;
    logic [2:0] exp_light;
    int         exp_dur;
    int         exp_en;
  } vec_t;
  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at the first sample of a phase (or at sample index 'start' within it);
  // returns at the first sample of the following phase.
  task automatic hold_len(input logic [2:0] l, input int start, output int n, output int en);
    int viol;
    n = start;
    en = 0;
    viol = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (light !== l) break;
      n++;
      if (cnt_en) en++;
      if (cnt_init != 0) viol++;
    end
    chk("phase_no_reload", viol, 0);
  endtask

  task automatic reset_start();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int en;
    logic exp_l1;

    vecs[0] = '{1'b0, 1'b0, 3'b001, 61, 15};
    vecs[1] = '{1'b0, 1'b0, 3'b010, 13, 3};
    vecs[2] = '{1'b0, 1'b0, 3'b100, 73, 18};
    vecs[3] = '{1'b0, 1'b0, 3'b001, 61, 15};

    // Reset state
    #1;
    step();
    chk("rst_light", light, 0);
    chk("rst_cnt_init", cnt_init, 0);
    chk("rst_ped_wait", ped_wait, 0);
    chk("rst_cnt_en", cnt_en, 0);

    // Normal cycle
    rst_n = 1'b1;
    step();
    for (int v = 0; v < 4; v++) begin
      ped_req = vecs[v].ped;
      flash_req = vecs[v].flash;
      chk("cyc_light", light, vecs[v].exp_light);
      chk("cyc_init_pulse", cnt_init, vecs[v].exp_light);
      chk("cyc_en_at_entry", cnt_en, 0);
      hold_len(vecs[v].exp_light, 1, n, en);
      chk("cyc_duration", n, vecs[v].exp_dur);
      chk("cyc_en_pulses", en, vecs[v].exp_en);
    end

    // Pedestrian shortening: request at 10 cycles into GREEN (cnt_val 12)
    reset_start();
    repeat (10) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("ped_wait_set", ped_wait, 1);
    chk("ped_still_green", light, 3'b001);
    step();
    chk("ped_early_yellow", light, 3'b010);
    chk("ped_yellow_init", cnt_init, 3'b010);
    chk("ped_wait_in_yellow", ped_wait, 1);
    repeat (6) step();
    chk("ped_wait_mid_yellow", ped_wait, 1);
    hold_len(3'b010, 7, n, en);
    chk("ped_yellow_dur", n, 13);
    chk("ped_red_light", light, 3'b100);
    chk("ped_wait_clr_red", ped_wait, 0);

    // Late pedestrian (cnt_val 4): no shortening
    reset_start();
    repeat (41) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("late_ped_wait", ped_wait, 1);
    hold_len(3'b001, 43, n, en);
    chk("late_green_dur", n, 61);
    chk("late_wait_yellow", ped_wait, 1);
    hold_len(3'b010, 1, n, en);
    chk("late_yellow_dur", n, 13);
    chk("late_wait_red", ped_wait, 0);
    // Request during RED shortens the next GREEN to 2 cycles
    repeat (5) step();
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("red_ped_wait", ped_wait, 1);
    hold_len(3'b100, 7, n, en);
    chk("red_dur", n, 73);
    chk("next_green_light", light, 3'b001);
    chk("next_green_wait", ped_wait, 1);
    hold_len(3'b001, 1, n, en);
    chk("short_green_dur", n, 2);
    chk("short_green_yellow", light, 3'b010);

    // Flash and ped on the GREEN expiry edge
    reset_start();
    repeat (60) step();
    chk("sim_pre_green", light, 3'b001);
    flash_req = 1'b1;
    ped_req = 1'b1;
    step();
    chk("sim_flash_light", light, 3'b010);
    chk("sim_ped_wait", ped_wait, 0);
    chk("sim_cnt_init", cnt_init, 0);
    flash_req = 1'b0;
    ped_req = 1'b0;
    step();
    chk("sim_exit_light", light, 3'b100);
    chk("sim_exit_init", cnt_init, 3'b100);

    // Flash mid-RED for 40 cycles
    reset_start();
    hold_len(3'b001, 1, n, en);
    hold_len(3'b010, 1, n, en);
    chk("fl_red_entry", light, 3'b100);
    repeat (10) step();
    flash_req = 1'b1;
    exp_l1 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      step();
      if (j >= 2 && (j - 2) % 4 == 0) exp_l1 = ~exp_l1;
      chk("fl_light", light, {1'b0, exp_l1, 1'b0});
      chk("fl_cnt_init", cnt_init, 0);
      chk("fl_cnt_en", cnt_en, 0);
      chk("fl_ped_wait", ped_wait, 0);
      ped_req = (j == 5);
      if (j == 39) flash_req = 1'b0;
    end
    ped_req = 1'b0;
    step();
    chk("fl_exit_light", light, 3'b100);
    chk("fl_exit_init", cnt_init, 3'b100);
    hold_len(3'b100, 1, n, en);
    chk("fl_red_dur", n, 73);
    chk("fl_red_en", en, 18);

    // Reset mid-YELLOW for 2 edges, then a sub-cycle glitch
    reset_start();
    hold_len(3'b001, 1, n, en);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("mrst_light", light, 0);
    chk("mrst_cnt_init", cnt_init, 0);
    chk("mrst_ped_wait", ped_wait, 0);
    chk("mrst_cnt_en", cnt_en, 0);
    step();
    chk("mrst_light2", light, 0);
    rst_n = 1'b1;
    step();
    chk("mrst_green", light, 3'b001);
    chk("mrst_green_init", cnt_init, 3'b001);
    repeat (3) step();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    chk("glitch_light", light, 3'b001);
    hold_len(3'b001, 5, n, en);
    chk("glitch_green_dur", n, 61);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
